// File: rtl/slsu_if.sv
// Request, data-memory and response signal bundle for the load/store unit.
// The slave modport is the unit's view; master is the requester/memory side.
interface slsu_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [4:0]            req_rd_i;

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [1:0]            mem_size_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic [4:0]            rsp_rd_o;
  logic                  rsp_err_o;

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i,
    input  req_addr_i, req_wdata_i, req_rd_i,
    input  mem_rdata_i, rsp_ready_i,
    output req_ready_o,
    output mem_read_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o,
    output rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i,
    output req_addr_i, req_wdata_i, req_rd_i,
    output mem_rdata_i, rsp_ready_i,
    input  req_ready_o,
    input  mem_read_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o,
    input  rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_err_o
  );
endinterface

// File: rtl/slsu.sv
// Single-issue load/store unit: accepts one request, checks alignment/bounds,
// performs one memory access and returns an extended load result or a fault.
module slsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1024
) (
  input logic   clk,
  input logic   rst,
  slsu_if.slave bus
);

  localparam int unsigned RD_W   = 5;
  localparam int unsigned SIZE_W = 2;
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_SIZE - 3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  logic                  write_q;
  logic                  unsigned_q;
  logic [SIZE_W-1:0]     size_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [RD_W-1:0]       rd_q;
  logic                  ready_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic                  fault_c;
  logic [DATA_WIDTH-1:0] load_ext_c;

  // Misalignment for the requested size, or any access reaching past the top word.
  always_comb begin
    fault_c = 1'b0;
    if (bus.req_addr_i >= ADDR_LIMIT) begin
      fault_c = 1'b1;
    end
    case (bus.req_size_i)
      2'b00:   ;
      2'b01:   if (bus.req_addr_i[0]) fault_c = 1'b1;
      default: if (bus.req_addr_i[1:0] != 2'b00) fault_c = 1'b1;
    endcase
  end

  // Memory-side extension is ignored; the low bytes are re-extended here.
  always_comb begin
    load_ext_c = bus.mem_rdata_i;
    case (size_q)
      2'b00: begin
        if (unsigned_q) load_ext_c = DATA_WIDTH'(bus.mem_rdata_i[7:0]);
        else            load_ext_c = {{(DATA_WIDTH-8){bus.mem_rdata_i[7]}}, bus.mem_rdata_i[7:0]};
      end
      2'b01: begin
        if (unsigned_q) load_ext_c = DATA_WIDTH'(bus.mem_rdata_i[15:0]);
        else            load_ext_c = {{(DATA_WIDTH-16){bus.mem_rdata_i[15]}}, bus.mem_rdata_i[15:0]};
      end
      default: load_ext_c = bus.mem_rdata_i;
    endcase
  end

  // Async reset clears the strobe flops immediately, so a reset mid-ACCESS
  // cannot let a write land at the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      ready_q     <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i && ready_q) begin
            write_q    <= bus.req_write_i;
            unsigned_q <= bus.req_unsigned_i;
            size_q     <= bus.req_size_i;
            addr_q     <= bus.req_addr_i;
            wdata_q    <= bus.req_wdata_i;
            rd_q       <= bus.req_rd_i;
            ready_q    <= 1'b0;
            if (fault_c) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state       <= ACCESS;
              mem_read_q  <= ~bus.req_write_i;
              mem_write_q <= bus.req_write_i;
            end
          end
        end
        ACCESS: begin
          state       <= RESP;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= write_q ? '0 : load_ext_c;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          ready_q     <= 1'b1;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.mem_read_o  = mem_read_q;
  assign bus.mem_write_o = mem_write_q;
  assign bus.mem_size_o  = size_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_rd_o    = rd_q;
  assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_slsu.sv
// Bench for slsu: byte-array memory, reference byte model, directed cases
// followed by randomized load/store traffic.
module tb_slsu;

  localparam int unsigned DW  = 32;
  localparam int unsigned MEM = 1024;
  localparam int unsigned AW  = 10;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   strobes;

  logic [7:0] mem     [0:MEM-1];
  logic [7:0] ref_mem [0:MEM-1];

  slsu_if #(.DATA_WIDTH(DW)) bus ();

  slsu #(.DATA_WIDTH(DW), .MEM_SIZE(MEM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational little-endian read of four bytes; upper bytes are raw memory.
  always_comb begin
    logic [AW-1:0] a;
    bus.mem_rdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      a = bus.mem_addr_o[AW-1:0] + AW'(i);
      bus.mem_rdata_i[8*i +: 8] = mem[a];
    end
  end

  always @(posedge clk) begin
    int n;
    logic [AW-1:0] a;
    if (bus.mem_read_o || bus.mem_write_o) strobes <= strobes + 1;
    if (bus.mem_write_o) begin
      n = (bus.mem_size_o == 2'b00) ? 1 : (bus.mem_size_o == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
        a = bus.mem_addr_o[AW-1:0] + AW'(i);
        mem[a] <= bus.mem_wdata_o[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input logic [31:0] addr, input logic [1:0] sz);
    longint a;
    a = longint'(addr);
    if (a >= longint'(MEM) - 3) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz[1] && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz,
                                             input bit uns);
    int     n;
    longint v;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v += (longint'(1) << 32) - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wdata);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
  endtask

  // One complete request/response, checked cycle by cycle against the model.
  task automatic run_req(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input int stall, output logic [31:0] got);
    bit          flt;
    logic [31:0] exp;
    int          s0;
    flt = model_fault(addr, sz);
    exp = (flt || wr) ? 32'd0 : model_load(addr, sz, uns);
    @(negedge clk);
    check("ready_idle", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_write_i    = wr;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    bus.req_rd_i       = rd;
    bus.rsp_ready_i    = 1'b0;
    s0 = strobes;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    if (!flt) begin
      check("access_read", 32'(bus.mem_read_o), 32'(!wr));
      check("access_write", 32'(bus.mem_write_o), 32'(wr));
      check("access_addr", bus.mem_addr_o, addr);
      check("access_size", 32'(bus.mem_size_o), 32'(sz));
      if (wr) check("access_wdata", bus.mem_wdata_o, wdata);
      check("access_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      @(negedge clk);
    end
    check("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("rsp_err", 32'(bus.rsp_err_o), 32'(flt));
    check("rsp_data", bus.rsp_data_o, exp);
    check("rsp_rd", 32'(bus.rsp_rd_o), 32'(rd));
    check("rsp_no_strobe", 32'(bus.mem_read_o | bus.mem_write_o), 32'd0);
    check("rsp_not_ready", 32'(bus.req_ready_o), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("stall_data", bus.rsp_data_o, exp);
    end
    got = bus.rsp_data_o;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("after_hs_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("after_hs_ready", 32'(bus.req_ready_o), 32'd1);
    check("strobe_count", 32'(strobes - s0), flt ? 32'd0 : 32'd1);
    if (!flt && wr) model_store(addr, sz, wdata);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] exp_word;
    logic [31:0] addr;
    logic [1:0]  sz;
    int          s0;
    int          pick;
    checks  = 0;
    errors  = 0;
    strobes = 0;
    for (int i = 0; i < MEM; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    bus.req_valid_i    = 1'b0;
    bus.req_write_i    = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_wdata_i    = '0;
    bus.req_rd_i       = '0;
    bus.rsp_ready_i    = 1'b0;
    rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_strobes", 32'(bus.mem_read_o | bus.mem_write_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    check("rst_rsp_data", bus.rsp_data_o, 32'd0);
    check("rst_addr", bus.mem_addr_o, 32'd0);
    rst = 1'b0;

    // Store word, then read back its bytes from memory
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, 0, got);
    check("sw_data_zero", got, 32'd0);
    check("sw_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'hDEADBEEF);

    // Byte loads over 0xFFFFFFEF
    mem[16] = 8'hEF; mem[17] = 8'hFF; mem[18] = 8'hFF; mem[19] = 8'hFF;
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hFF; ref_mem[18] = 8'hFF; ref_mem[19] = 8'hFF;
    run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 5'd9, 0, got);
    check("lb_value", got, 32'hFFFFFFEF);
    run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, 5'd10, 1, got);
    check("lbu_value", got, 32'h000000EF);

    // Half loads over 0x00008001
    mem[18] = 8'h01; mem[19] = 8'h80; mem[20] = 8'h00; mem[21] = 8'h00;
    ref_mem[18] = 8'h01; ref_mem[19] = 8'h80; ref_mem[20] = 8'h00; ref_mem[21] = 8'h00;
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 5'd11, 0, got);
    check("lh_value", got, 32'hFFFF8001);
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 5'd12, 0, got);
    check("lhu_value", got, 32'h00008001);

    // Faults: misaligned word, and word at the top boundary
    run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 5'd13, 0, got);
    run_req(1'b0, 2'b10, 1'b0, 32'h3FD, 32'd0, 5'd14, 1, got);
    run_req(1'b0, 2'b00, 1'b0, 32'(MEM - 4), 32'd0, 5'd15, 0, got);
    run_req(1'b1, 2'b00, 1'b0, 32'(MEM - 3), 32'h55, 5'd16, 0, got);

    // Back-pressure with a request held valid
    exp_word = model_load(32'h20, 2'b10, 1'b0);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_size_i  = 2'b10;
    bus.req_addr_i  = 32'h20;
    bus.req_rd_i    = 5'd7;
    s0 = strobes;
    @(posedge clk);
    @(negedge clk);
    check("bp_read", 32'(bus.mem_read_o), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("bp_data", bus.rsp_data_o, exp_word);
      check("bp_rd", 32'(bus.rsp_rd_o), 32'd7);
      check("bp_not_ready", 32'(bus.req_ready_o), 32'd0);
      @(negedge clk);
    end
    check("bp_one_access", 32'(strobes - s0), 32'd1);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("bp_hs_ready", 32'(bus.req_ready_o), 32'd1);
    check("bp_no_accept_at_hs", 32'(strobes - s0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("bp_second_read", 32'(bus.mem_read_o), 32'd1);
    @(negedge clk);
    check("bp_second_data", bus.rsp_data_o, exp_word);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;

    // Reset during a store access
    mem[64] = 8'h11;
    ref_mem[64] = 8'h11;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_size_i  = 2'b00;
    bus.req_addr_i  = 32'h40;
    bus.req_wdata_i = 32'h5A;
    bus.req_rd_i    = 5'd20;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("rstacc_write", 32'(bus.mem_write_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rstacc_write_drop", 32'(bus.mem_write_o), 32'd0);
    check("rstacc_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rstacc_ready", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    check("rstacc_mem", 32'(mem[64]), 32'h11);
    check("rstacc_rsp_after", 32'(bus.rsp_valid_o), 32'd0);
    rst = 1'b0;

    // Randomized traffic against the byte model
    for (int t = 0; t < 80; t++) begin
      sz   = 2'($urandom_range(0, 3));
      pick = int'($urandom_range(0, 3));
      case (pick)
        0: begin
          addr = 32'($urandom_range(0, MEM - 4));
          if (sz == 2'b01) addr[0] = 1'b0;
          if (sz[1]) addr[1:0] = 2'b00;
        end
        1:       addr = 32'($urandom_range(0, MEM - 1));
        2:       addr = 32'($urandom_range(MEM - 8, MEM - 1));
        default: addr = $urandom;
      endcase
      run_req(1'($urandom), sz, 1'($urandom), addr, $urandom, 5'($urandom),
              int'($urandom_range(0, 2)), got);
    end

    // Final memory image must match the model
    for (int i = 0; i < int'(MEM); i += 64) check("mem_image", 32'(mem[i]), 32'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
